// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode / register-read stage: register file, opcode/immediate build,
// forward flags and the single output pipeline register.
module decode_stage #(
  parameter int          XLEN   = 32,
  parameter logic [11:0] NOP_OP = 12'b000000010011
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            valid_in,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [11:0]     operation,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rd,
  output logic [1:0]      need_forward,
  output logic [XLEN-1:0] pc,
  output logic            valid_out,
  output logic            reg_write
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic [XLEN-1:0] regs [32];

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd_f, rs1_f, rs2_f;
  logic            is_r, is_i, is_s, is_b, is_u, is_j;
  logic            use_rs1, use_rs2, writes_rd;
  logic [XLEN-1:0] imm_d, rs1_d, rs2_d;
  logic [11:0]     op_d;
  logic [1:0]      fwd_d;

  assign opcode = instr_in[6:0];
  assign funct3 = instr_in[14:12];
  assign rd_f   = instr_in[11:7];
  assign rs1_f  = instr_in[19:15];
  assign rs2_f  = instr_in[24:20];

  always_comb begin
    is_r = (opcode == OPC_OP);
    is_i = (opcode == OPC_OP_IMM) || (opcode == OPC_LOAD) || (opcode == OPC_JALR);
    is_s = (opcode == OPC_STORE);
    is_b = (opcode == OPC_BRANCH);
    is_u = (opcode == OPC_LUI) || (opcode == OPC_AUIPC);
    is_j = (opcode == OPC_JAL);
    use_rs1   = is_r || is_i || is_s || is_b;
    use_rs2   = is_r || is_s || is_b;
    writes_rd = (is_r || is_i || is_u || is_j) && (rd_f != 5'd0);
  end

  always_comb begin
    imm_d = '0;
    if (is_i)
      imm_d = {{20{instr_in[31]}}, instr_in[31:20]};
    else if (is_s)
      imm_d = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    else if (is_b)
      imm_d = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
    else if (is_u)
      imm_d = {instr_in[31:12], 12'b0};
    else if (is_j)
      imm_d = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
  end

  // instr[30]/instr[25] only carry function bits for R-type (and instr[30] for SRLI/SRAI);
  // elsewhere they are immediate bits and are masked so e.g. ADDI -1 still decodes as ADDI.
  always_comb begin
    op_d = {2'b00, funct3, opcode};
    if (is_r)
      op_d = {instr_in[30], instr_in[25], funct3, opcode};
    else if ((opcode == OPC_OP_IMM) && (funct3 == 3'b101))
      op_d = {instr_in[30], 1'b0, funct3, opcode};
  end

  // Write-first bypass covers the distance-2 dependency through writeback.
  always_comb begin
    rs1_d = '0;
    rs2_d = '0;
    if (rs1_f != 5'd0)
      rs1_d = (wb_en && (wb_addr == rs1_f)) ? wb_data : regs[rs1_f];
    if (rs2_f != 5'd0)
      rs2_d = (wb_en && (wb_addr == rs2_f)) ? wb_data : regs[rs2_f];
  end

  // The output register is the copy of the previously issued instruction.
  always_comb begin
    fwd_d    = 2'b00;
    fwd_d[0] = valid_out && reg_write && (rd != 5'd0) && (rd == rs1_f) && use_rs1;
    fwd_d[1] = valid_out && reg_write && (rd != 5'd0) && (rd == rs2_f) && use_rs2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && !valid_in)) begin
      operation    <= NOP_OP;
      rs1          <= '0;
      rs2          <= '0;
      imm          <= '0;
      rd           <= 5'd0;
      need_forward <= 2'b00;
      pc           <= '0;
      valid_out    <= 1'b0;
      reg_write    <= 1'b0;
    end else if (!stall) begin
      operation    <= op_d;
      rs1          <= rs1_d;
      rs2          <= rs2_d;
      imm          <= imm_d;
      rd           <= writes_rd ? rd_f : 5'd0;
      need_forward <= fwd_d;
      pc           <= pc_in;
      valid_out    <= 1'b1;
      reg_write    <= writes_rd;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed and randomized checks of decode_stage against a
// reference model that applies writeback first and decodes by instruction class.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_in, pc_in, wb_data;
  logic        valid_in, stall, flush, wb_en;
  logic [4:0]  wb_addr;
  logic [11:0] operation;
  logic [31:0] rs1, rs2, imm, pc;
  logic [4:0]  rd;
  logic [1:0]  need_forward;
  logic        valid_out, reg_write;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [11:0] op;
    logic [31:0] r1, r2, imm, pc;
    logic [4:0]  rd;
    logic [1:0]  nf;
    logic        v, rw;
  } out_t;

  out_t        e;
  logic [31:0] mr [32];
  logic [6:0]  opc [10];

  decode_stage dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .pc_in(pc_in), .valid_in(valid_in),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .operation(operation), .rs1(rs1), .rs2(rs2), .imm(imm), .rd(rd),
    .need_forward(need_forward), .pc(pc), .valid_out(valid_out), .reg_write(reg_write)
  );

  always #5 clk = ~clk;

  function automatic out_t bubble();
    out_t b;
    b.op = 12'b000000010011; b.r1 = 0; b.r2 = 0; b.imm = 0; b.pc = 0;
    b.rd = 0; b.nf = 2'b00; b.v = 1'b0; b.rw = 1'b0;
    return b;
  endfunction

  // Class letters: R I S B U J, anything else 'X'.
  function automatic byte kind_of(input logic [6:0] o);
    case (o)
      7'h33:               return "R";
      7'h13, 7'h03, 7'h67: return "I";
      7'h23:               return "S";
      7'h63:               return "B";
      7'h37, 7'h17:        return "U";
      7'h6F:               return "J";
      default:             return "X";
    endcase
  endfunction

  function automatic out_t decode_ref(input logic [31:0] i, input logic [31:0] p, input out_t prev);
    out_t n;
    byte  k;
    int   v;
    logic u1, u2, wr;
    k  = kind_of(i[6:0]);
    u1 = (k == "R") || (k == "I") || (k == "S") || (k == "B");
    u2 = (k == "R") || (k == "S") || (k == "B");
    wr = (k == "R") || (k == "I") || (k == "U") || (k == "J");
    case (k)
      "I": v = int'($signed(i)) >>> 20;
      "S": v = (int'($signed(i)) >>> 25) * 32 + int'(i[11:7]);
      "B": v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      "U": v = int'(i & 32'hFFFFF000);
      "J": v = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
      default: v = 0;
    endcase
    n.imm = v;
    if (k == "R")                              n.op = {i[30], i[25], i[14:12], i[6:0]};
    else if (i[6:0] == 7'h13 && i[14:12] == 5) n.op = {i[30], 1'b0, i[14:12], i[6:0]};
    else                                       n.op = {2'b00, i[14:12], i[6:0]};
    n.r1 = mr[i[19:15]];
    n.r2 = mr[i[24:20]];
    n.rw = wr && (i[11:7] != 0);
    n.rd = n.rw ? i[11:7] : 5'd0;
    n.pc = p;
    n.v  = 1'b1;
    n.nf[0] = prev.v && prev.rw && prev.rd != 0 && prev.rd == i[19:15] && u1;
    n.nf[1] = prev.v && prev.rw && prev.rd != 0 && prev.rd == i[24:20] && u2;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  task automatic check_all();
    chk("operation", {20'd0, operation}, {20'd0, e.op});
    chk("rs1", rs1, e.r1);
    chk("rs2", rs2, e.r2);
    chk("imm", imm, e.imm);
    chk("rd", {27'd0, rd}, {27'd0, e.rd});
    chk("need_forward", {30'd0, need_forward}, {30'd0, e.nf});
    chk("pc", pc, e.pc);
    chk("valid_out", {31'd0, valid_out}, {31'd0, e.v});
    chk("reg_write", {31'd0, reg_write}, {31'd0, e.rw});
  endtask

  task automatic step(input logic [31:0] ins, input logic [31:0] p, input logic v, input logic st,
                      input logic fl, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic rs);
    out_t nx;
    instr_in = ins; pc_in = p; valid_in = v; stall = st; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd; reset = rs;
    if (rs) begin
      for (int r = 0; r < 32; r++) mr[r] = 0;
      e = bubble();
    end else begin
      if (we && wa != 0) mr[wa] = wd;
      nx = decode_ref(ins, p, e);
      if (fl || (!st && !v)) e = bubble();
      else if (!st)          e = nx;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] r;
    int          n;
    opc = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73};
    e = bubble();

    step(32'h0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(32'h0, 0, 0, 1, 1, 1, 5'd7, 32'h55, 1);
    chk("reset_op", {20'd0, operation}, 32'h013);

    step(32'h0, 0, 0, 0, 0, 1, 5'd5, 32'h1234, 0);
    step(32'hFFF28313, 32'h4, 1, 0, 0, 0, 0, 0, 0);
    chk("addi_op", {20'd0, operation}, 32'h013);
    chk("addi_rs1", rs1, 32'h1234);
    chk("addi_imm", imm, 32'hFFFFFFFF);
    chk("addi_rd", {27'd0, rd}, 32'd6);

    step(32'h002081B3, 32'h8, 1, 0, 0, 0, 0, 0, 0);
    step(32'h40318233, 32'hC, 1, 0, 0, 0, 0, 0, 0);
    chk("sub_fwd", {30'd0, need_forward}, 32'd3);
    chk("sub_op", {20'd0, operation}, 32'h833);

    step(32'h00312423, 32'h10, 1, 0, 0, 0, 0, 0, 0);
    chk("sw_imm", imm, 32'd8);
    chk("sw_rw", {31'd0, reg_write}, 32'd0);
    step(32'h008004B3, 32'h14, 1, 0, 0, 0, 0, 0, 0);
    chk("after_sw_fwd", {30'd0, need_forward}, 32'd0);

    step(32'h001000EF, 32'h100, 1, 0, 0, 0, 0, 0, 0);
    for (int s = 0; s < 2; s++) begin
      step(32'h001000EF, 32'h100, 1, 1, 0, 1, 5'd9, 32'h99, 0);
      chk("stall_imm", imm, 32'h800);
      chk("stall_pc", pc, 32'h100);
      chk("stall_valid", {31'd0, valid_out}, 32'd1);
    end

    step(32'h00108393, 32'h104, 1, 0, 1, 0, 0, 0, 0);
    chk("flush_valid", {31'd0, valid_out}, 32'd0);
    step(32'h007382B3, 32'h108, 1, 0, 0, 0, 0, 0, 0);
    chk("post_flush_fwd", {30'd0, need_forward}, 32'd0);

    step(32'h0, 0, 0, 0, 0, 1, 5'd0, 32'hDEAD, 0);
    step(32'h000000B3, 32'h10C, 1, 0, 0, 1, 5'd0, 32'hDEAD, 0);
    chk("x0_rs1", rs1, 32'd0);
    chk("x0_rs2", rs2, 32'd0);
    step(32'h000000B3, 32'h10C, 1, 1, 0, 0, 0, 0, 1);
    chk("reset_in_stall", {31'd0, valid_out}, 32'd0);

    for (int t = 0; t < 400; t++) begin
      r = $urandom();
      n = $urandom_range(0, 9);
      r[6:0]   = opc[n];
      r[11:7]  = 5'($urandom_range(0, 3));
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      step(r, $urandom(), $urandom_range(0, 7) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
           $urandom(), $urandom_range(0, 99) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction decode / register-read stage. Sits directly upstream of the execute stage and feeds it.
- Holds the 32x32 integer register file and builds the 12-bit operation code and the immediate.
- Computes the need_forward flags the execute stage uses to select its forward operand.
- Registers all outputs in one pipeline register, with stall and flush control.

Parameters:
XLEN, 32, data/register width
NOP_OP, 12'b000000010011, operation code emitted for a bubble (ADDI x0,x0,0)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
instr_in  input  32  fetched instruction
pc_in  input  XLEN  PC of instr_in
valid_in  input  1  instr_in is valid
stall  input  1  hold the output register
flush  input  1  squash the instruction being decoded (branch/jump redirect)
wb_en  input  1  register-file write enable
wb_addr  input  5  write address
wb_data  input  XLEN  write data
operation  output  12  {instr[30], instr[25], funct3, opcode}
rs1  output  XLEN  rs1 operand value
rs2  output  XLEN  rs2 operand value
imm  output  XLEN  sign-extended immediate
rd  output  5  destination register
need_forward  output  2  bit0: execute replaces rs1 with forward; bit1: execute replaces rs2 with forward
pc  output  XLEN  PC of the decoded instruction
valid_out  output  1  output register holds a real instruction
reg_write  output  1  decoded instruction writes rd

Behaviour:
- Reset (posedge clk with reset=1):
  - all 32 registers cleared to 0;
  - operation=NOP_OP; rs1, rs2, imm, pc = 0; rd=0; need_forward=2'b00; valid_out=0; reg_write=0.
  - Reset overrides stall, flush and wb_en.
- Latency: 1 cycle. Instruction presented in cycle t appears on outputs after posedge t+1.
- Priority: reset > flush > stall > normal load.
- Flush:
  - loads a bubble: operation=NOP_OP, rd=0, reg_write=0, valid_out=0, need_forward=0, imm=0;
  - pc and rs1/rs2 don't-care, driven 0.
- Stall (no flush): all outputs hold. The upstream stage holds instr_in.
- valid_in=0 (no stall/flush): loads a bubble, same as flush.
- Register file:
  - writes on posedge when wb_en=1 and wb_addr!=0;
  - x0 always reads 0;
  - write-first bypass: if wb_en and wb_addr==rs1 field (!=0), rs1 captures wb_data; same rule for rs2.
- Immediate by opcode:
  - I-type (0000011, 0010011, 1100111): sext instr[31:20].
  - S-type (0100011): sext {instr[31:25], instr[11:7]}.
  - B-type (1100011): sext {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): sext {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - Other opcodes: 0.
- reg_write:
  - 1 for opcodes 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111, when rd field !=0;
  - 0 for S and B types.
  - rd output = instr[11:7] for writers, else 0.
- Source usage:
  - rs1 used by R, I, S, B types;
  - rs2 used by R, S, B types;
  - U and J types use neither.
- need_forward: an internal copy of the previously issued instruction's {valid_out, reg_write, rd} is compared against the rs1/rs2 fields of the current instruction.
  - Bit set when the previous instruction is valid, writes, rd!=0, rd matches the field, and the source is used.
  - During stall the flags hold with the outputs; they are not recomputed.
  - After a flush bubble, the next instruction has need_forward=0.
- Distance-2 dependencies are covered by the wb bypass. Load-use stalls are not generated here.

Test Plan:
- Reset, then wb_en=1 wb_addr=5 wb_data=0x1234, then ADDI x6,x5,-1 (0xFFF28313) -> operation=12'b000000010011, rs1=0x1234, imm=0xFFFFFFFF, rd=6, reg_write=1, need_forward=00.
- ADD x3,x1,x2 (0x002081B3) directly followed by SUB x4,x3,x3 (0x40318233) -> second output need_forward=2'b11, operation=12'b100000110011.
- SW x3,8(x2) (0x00312423) -> imm=8, reg_write=0, rd=0. A following instruction reading x0 or x8 gets need_forward=00.
- JAL x1,+2048 (0x001000EF) at pc_in=0x100, stall high for 2 cycles -> outputs hold imm=0x800, pc=0x100, valid_out=1 for all stalled cycles.
- flush=1 while a valid instruction is presented -> operation=NOP_OP, valid_out=0, reg_write=0. A dependent next instruction gets need_forward=00.
- wb_en=1 wb_addr=0 wb_data=0xDEAD, then ADD x1,x0,x0 -> rs1=rs2=0. Assert reset during stall -> all outputs return to reset values on the next posedge.
